// File: rtl/chunk_streamer_pkg.sv
// Shared definitions for chunk_streamer: command word field positions,
// control-FSM state type and a counter-width helper.
package chunk_streamer_pkg;

  localparam int unsigned CMD_WEN_BIT  = 31;
  localparam int unsigned CMD_ADDR_MSB = 30;
  localparam int unsigned CMD_ADDR_LSB = 16;
  localparam int unsigned CMD_DATA_MSB = 15;
  localparam int unsigned CMD_ADDR_W   = CMD_ADDR_MSB - CMD_ADDR_LSB + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  // Width of a counter that must hold 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunk_assembler.sv
// chunk_assembler: collects CHUNK_WORDS read words into one packed chunk.
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        chunk consumed; drop the full flag
//   in_vld       a read address for this buffer is on the RAM this cycle
//   ram_dout     RAM read data
//   chunk        packed chunk, word k at [k*DATA_W +: DATA_W]
//   full         chunk complete and held
//   idle         empty with no read in flight (safe to start a new fill)
//   fill_done    the final word is captured at the coming edge
module chunk_assembler
  import chunk_streamer_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned CHUNK_WORDS = 16,
  parameter int unsigned RAM_LAT     = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          in_vld,
  input  logic [DATA_W-1:0]             ram_dout,
  output logic [DATA_W*CHUNK_WORDS-1:0] chunk,
  output logic                          full,
  output logic                          idle,
  output logic                          fill_done
);

  localparam int unsigned CNT_W = cnt_w(CHUNK_WORDS);

  logic [RAM_LAT-1:0] vpipe;
  logic [CNT_W-1:0]   cnt;
  logic               cap;

  // vpipe tracks which cycles carry read data belonging to this buffer.
  assign cap       = vpipe[RAM_LAT-1];
  assign fill_done = cap && (cnt == CNT_W'(CHUNK_WORDS - 1));
  assign idle      = !full && !in_vld && (vpipe == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe <= '0;
      cnt   <= '0;
      chunk <= '0;
      full  <= 1'b0;
    end else begin
      vpipe[0] <= in_vld;
      for (int unsigned i = 1; i < RAM_LAT; i++) vpipe[i] <= vpipe[i-1];
      if (cap) begin
        chunk[cnt*DATA_W +: DATA_W] <= ram_dout;
        cnt <= fill_done ? '0 : cnt + 1'b1;
      end
      if (fill_done)  full <= 1'b1;
      else if (clear) full <= 1'b0;
    end
  end

endmodule

// File: rtl/chunk_streamer.sv
// chunk_streamer: loads words into an external RAM from command words, then
// streams NUM_CHUNKS chunks of CHUNK_WORDS words from a base address.
//   cmd_word/cmd_valid   [31]=WEN, [30:16]=addr, [15:0]=data; write or start
//   cmd_drop             pulse: command arrived while busy and was discarded
//   ram_addr/wen/din     RAM port; ram_dout returns RAM_LAT cycles later
//   chunk_dout/valid     packed chunk, held until chunk_ready
//   busy, done           run in progress; pulse after final chunk accepted
// Build option: CHUNK_STREAMER_DBUF_EN adds a second chunk buffer so the
// fetch of chunk i+1 overlaps presentation of chunk i.
module chunk_streamer
  import chunk_streamer_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned CHUNK_WORDS = 16,
  parameter int unsigned NUM_CHUNKS  = 3,
  parameter int unsigned RAM_LAT     = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   cmd_word,
  input  logic                          cmd_valid,
  output logic                          cmd_drop,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic                          ram_wen,
  output logic [DATA_W-1:0]             ram_din,
  input  logic [DATA_W-1:0]             ram_dout,
  output logic [DATA_W*CHUNK_WORDS-1:0] chunk_dout,
  output logic                          chunk_valid,
  input  logic                          chunk_ready,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned CW    = DATA_W * CHUNK_WORDS;
  localparam int unsigned CNT_W = cnt_w(CHUNK_WORDS);
  localparam int unsigned IDX_W = cnt_w(NUM_CHUNKS + 1);
`ifdef CHUNK_STREAMER_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif
  localparam int unsigned NBUF = DBUF ? 2 : 1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cmd_addr, next_addr;
  logic [CNT_W-1:0]  k;
  logic [IDX_W-1:0]  fetch_cnt, pres_idx;
  logic              rd_issue, fill_buf, wr_buf, rd_buf;
  logic [1:0]        full_v, idle_v, fill_done_v;
  logic [CW-1:0]     chunk_v [2];
  logic              hs, last, start, wr_cmd, issue_last, can_launch;
  logic              rd_buf_nxt, valid_nxt;

  for (genvar b = 0; b < 2; b++) begin : g_buf
    if (b < NBUF) begin : g_on
      chunk_assembler #(
        .DATA_W      (DATA_W),
        .CHUNK_WORDS (CHUNK_WORDS),
        .RAM_LAT     (RAM_LAT)
      ) u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (hs && (rd_buf == 1'(b))),
        .in_vld    (rd_issue && (fill_buf == 1'(b))),
        .ram_dout  (ram_dout),
        .chunk     (chunk_v[b]),
        .full      (full_v[b]),
        .idle      (idle_v[b]),
        .fill_done (fill_done_v[b])
      );
    end else begin : g_off
      assign chunk_v[b]     = '0;
      assign full_v[b]      = 1'b0;
      assign idle_v[b]      = 1'b0;
      assign fill_done_v[b] = 1'b0;
    end
  end

  assign cmd_addr    = cmd_word[CMD_ADDR_LSB +: ADDR_W];
  assign chunk_dout  = chunk_v[rd_buf];
  assign chunk_valid = full_v[rd_buf];
  assign busy        = (state != ST_IDLE);

  always_comb begin
    hs         = chunk_valid && chunk_ready;
    last       = (pres_idx == IDX_W'(NUM_CHUNKS - 1));
    start      = (state == ST_IDLE) && cmd_valid && !cmd_word[CMD_WEN_BIT];
    wr_cmd     = (state == ST_IDLE) && cmd_valid && cmd_word[CMD_WEN_BIT];
    issue_last = rd_issue && (k == CNT_W'(CHUNK_WORDS - 1));
    // A new chunk fetch starts once the address stream is free and its target
    // buffer is empty, or is being emptied by a handshake at this edge.
    can_launch = (state != ST_IDLE) && !done && (fetch_cnt < IDX_W'(NUM_CHUNKS)) &&
                 (!rd_issue || issue_last) &&
                 (idle_v[wr_buf] || (hs && (rd_buf == wr_buf)));
    rd_buf_nxt = (hs && DBUF) ? ~rd_buf : rd_buf;
    valid_nxt  = (full_v[rd_buf_nxt] && !(hs && (rd_buf_nxt == rd_buf))) ||
                 fill_done_v[rd_buf_nxt];
    state_nxt  = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_READ;
      default: begin
        // One drain cycle after the final handshake keeps busy high alongside done.
        if (done)               state_nxt = ST_IDLE;
        else if (hs && last)    state_nxt = ST_READ;
        else                    state_nxt = valid_nxt ? ST_PRESENT : ST_READ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr  <= '0;
      ram_wen   <= 1'b0;
      ram_din   <= '0;
      cmd_drop  <= 1'b0;
      done      <= 1'b0;
      next_addr <= '0;
      k         <= '0;
      rd_issue  <= 1'b0;
      fill_buf  <= 1'b0;
      wr_buf    <= 1'b0;
      rd_buf    <= 1'b0;
      fetch_cnt <= '0;
      pres_idx  <= '0;
    end else begin
      ram_wen  <= wr_cmd;
      cmd_drop <= cmd_valid && (state != ST_IDLE);
      done     <= hs && last;
      if (wr_cmd) begin
        ram_addr <= cmd_addr;
        ram_din  <= cmd_word[CMD_DATA_MSB -: DATA_W];
      end
      if (start) begin
        ram_addr  <= cmd_addr;
        next_addr <= cmd_addr + ADDR_W'(CHUNK_WORDS);
        rd_issue  <= 1'b1;
        k         <= '0;
        fill_buf  <= 1'b0;
        wr_buf    <= DBUF;
        rd_buf    <= 1'b0;
        fetch_cnt <= IDX_W'(1);
        pres_idx  <= '0;
      end else if (can_launch) begin
        ram_addr  <= next_addr;
        next_addr <= next_addr + ADDR_W'(CHUNK_WORDS);
        rd_issue  <= 1'b1;
        k         <= '0;
        fill_buf  <= wr_buf;
        wr_buf    <= DBUF ? ~wr_buf : 1'b0;
        fetch_cnt <= fetch_cnt + 1'b1;
      end else if (rd_issue) begin
        if (issue_last) begin
          rd_issue <= 1'b0;
        end else begin
          ram_addr <= ram_addr + 1'b1;
          k        <= k + 1'b1;
        end
      end
      if (hs) begin
        pres_idx <= pres_idx + 1'b1;
        rd_buf   <= rd_buf_nxt;
      end
    end
  end

endmodule
